// File: rtl/loop_ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// loop_ram_arbiter_if
// Command bus between the loop RAM arbiter and the async-RAM controller.
//   req    transaction request, held until done (or abort)
//   we     1 = write, 0 = read; stable while req
//   addr   RAM word address; stable while req
//   wdata  write data; stable while req
//   rdata  read data, valid in the done cycle
//   done   one-cycle completion pulse from the RAM controller
// Modports: master = arbiter side, slave = RAM controller side.
// ----------------------------------------------------------------------------
interface loop_ram_arbiter_if #(
  parameter int MEM_AW = 23
);
  logic              req;
  logic              we;
  logic [MEM_AW-1:0] addr;
  logic [15:0]       wdata;
  logic [15:0]       rdata;
  logic              done;

  modport master (output req, we, addr, wdata, input rdata, done);
  modport slave  (input req, we, addr, wdata, output rdata, done);
endinterface

// File: rtl/loop_ram_arbiter.sv
// ----------------------------------------------------------------------------
// loop_ram_arbiter
// Shares one async-RAM command port between a record stream (samples in) and
// a playback stream (samples out). Keeps record/play pointers for a looped
// buffer, arbitrates round-robin, sequences each RAM transaction and aborts a
// RAM cycle that never completes.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   rec_en/valid/data    record stream in; rec_ready = holding register empty
//   play_req             one-cycle request for the next playback sample
//   play_valid/data      one-cycle pulse with the fetched sample
//   loop_len             loop length in samples, 0 means 2**ADDR_W
//   clear                zero pointers, drop pending work, clear sticky flags
//   mem                  RAM command bus (loop_ram_arbiter_if.master)
//   rec_ptr, play_ptr    next record / playback index
//   play_ovr             sticky: play_req while a play request was pending
//   err_timeout          sticky: a RAM transaction timed out
//
// Build option: define OVERDUB_EN to make each record a read-modify-write
// (old + new, saturated to 16 bits) instead of a plain write.
// ----------------------------------------------------------------------------
module loop_ram_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int MEM_AW      = 23,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rec_en,
  input  logic                rec_valid,
  input  logic signed [15:0]  rec_data,
  output logic                rec_ready,
  input  logic                play_req,
  output logic                play_valid,
  output logic signed [15:0]  play_data,
  input  logic [ADDR_W-1:0]   loop_len,
  input  logic                clear,
  loop_ram_arbiter_if.master  mem,
  output logic [ADDR_W-1:0]   rec_ptr,
  output logic [ADDR_W-1:0]   play_ptr,
  output logic                play_ovr,
  output logic                err_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR
`ifdef OVERDUB_EN
    ,
    ODRD,
    ODWR
`endif
  } state_t;

  state_t             state;
  logic               pend;       // play request waiting for (or in) a RAM read
  logic               hold_full;
  logic signed [15:0] hold_data;
  logic               clr_lat;    // clear seen mid-transaction, applied at its end
  logic               lg_play;    // last grant: 1 = play, 0 = record
  logic [CW-1:0]      wcnt;

  logic tmo, fin, rd_fin, do_clear, grant_rd, grant_wr;

  function automatic logic [ADDR_W-1:0] adv(input logic [ADDR_W-1:0] p,
                                            input logic [ADDR_W-1:0] len_in);
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] nxt;
    len = (len_in == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, len_in};
    nxt = {1'b0, p} + (ADDR_W+1)'(1);
    // >= so a pointer left beyond a shrunk loop wraps on its next advance
    return (nxt >= len) ? '0 : nxt[ADDR_W-1:0];
  endfunction

  function automatic logic [MEM_AW-1:0] addr_of(input logic [ADDR_W-1:0] p);
    return MEM_AW'(BASE_ADDR) + MEM_AW'(p);
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    logic signed [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s[16] != s[15]) return s[16] ? 16'sh8000 : 16'sh7FFF;
    return s[15:0];
  endfunction

  assign rec_ready = rec_en & ~hold_full;

  // Timeout fires on the last allowed cycle with req high; a done in that same
  // cycle still wins.
  assign tmo = mem.req && !mem.done && (wcnt == CW'(TIMEOUT_CYC - 1));

  // Round-robin only matters when both sides want the port.
  assign grant_rd = pend && (!hold_full || !lg_play);
  assign grant_wr = hold_full && (!pend || lg_play);

  always_comb begin
    fin    = 1'b0;
    rd_fin = 1'b0;
    if (mem.req && (mem.done || tmo)) begin
      case (state)
        RD:   begin fin = 1'b1; rd_fin = 1'b1; end
        WR:   fin = 1'b1;
`ifdef OVERDUB_EN
        // A finished overdub read only ends the transaction if aborted.
        ODRD: fin = tmo || clr_lat || clear;
        ODWR: fin = 1'b1;
`endif
        default: fin = 1'b0;
      endcase
    end
  end

  assign do_clear = (clear && state == IDLE) || (fin && (clr_lat || clear));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend        <= 1'b0;
      hold_full   <= 1'b0;
      clr_lat     <= 1'b0;
      lg_play     <= 1'b0;
      wcnt        <= '0;
      play_valid  <= 1'b0;
      play_data   <= '0;
      mem.req     <= 1'b0;
      mem.we      <= 1'b0;
      mem.addr    <= '0;
      mem.wdata   <= '0;
      rec_ptr     <= '0;
      play_ptr    <= '0;
      play_ovr    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      play_valid <= 1'b0;
      if (mem.req) wcnt <= wcnt + 1'b1;

      if (rec_valid && rec_ready) begin
        hold_full <= 1'b1;
        hold_data <= rec_data;
      end

      // A request landing in the cycle its predecessor completes is a new
      // request, not an overrun.
      if (play_req) begin
        if (pend && !rd_fin) play_ovr <= 1'b1;
        pend <= 1'b1;
      end else if (rd_fin) begin
        pend <= 1'b0;
      end

      if (clear && state != IDLE) clr_lat <= 1'b1;

      case (state)
        IDLE: begin
          if (!clear) begin
            if (grant_rd) begin
              state    <= RD;
              mem.req  <= 1'b1;
              mem.we   <= 1'b0;
              mem.addr <= addr_of(play_ptr);
              lg_play  <= 1'b1;
              wcnt     <= '0;
            end else if (grant_wr) begin
`ifdef OVERDUB_EN
              state    <= ODRD;
              mem.we   <= 1'b0;
`else
              state    <= WR;
              mem.we   <= 1'b1;
`endif
              mem.req   <= 1'b1;
              mem.addr  <= addr_of(rec_ptr);
              mem.wdata <= hold_data;
              lg_play   <= 1'b0;
              wcnt      <= '0;
            end
          end
        end
        RD: begin
          if (fin) begin
            mem.req    <= 1'b0;
            state      <= IDLE;
            play_valid <= 1'b1;
            play_data  <= mem.done ? mem.rdata : '0;
            play_ptr   <= adv(play_ptr, loop_len);
            if (tmo) err_timeout <= 1'b1;
          end
        end
        WR: begin
          if (fin) begin
            mem.req   <= 1'b0;
            state     <= IDLE;
            hold_full <= 1'b0;
            rec_ptr   <= adv(rec_ptr, loop_len);
            if (tmo) err_timeout <= 1'b1;
          end
        end
`ifdef OVERDUB_EN
        ODRD: begin
          if (fin) begin
            mem.req   <= 1'b0;
            state     <= IDLE;
            hold_full <= 1'b0;
            rec_ptr   <= adv(rec_ptr, loop_len);
            if (tmo) err_timeout <= 1'b1;
          end else if (mem.req && mem.done) begin
            // Drop req for one cycle between the read and the write half.
            mem.req   <= 1'b0;
            mem.we    <= 1'b1;
            mem.wdata <= sat16(mem.rdata, hold_data);
            state     <= ODWR;
          end
        end
        ODWR: begin
          if (!mem.req) begin
            mem.req <= 1'b1;
            wcnt    <= '0;
          end else if (fin) begin
            mem.req   <= 1'b0;
            state     <= IDLE;
            hold_full <= 1'b0;
            rec_ptr   <= adv(rec_ptr, loop_len);
            if (tmo) err_timeout <= 1'b1;
          end
        end
`endif
        default: begin
          mem.req <= 1'b0;
          state   <= IDLE;
        end
      endcase

      if (do_clear) begin
        rec_ptr     <= '0;
        play_ptr    <= '0;
        pend        <= 1'b0;
        hold_full   <= 1'b0;
        play_ovr    <= 1'b0;
        err_timeout <= 1'b0;
        clr_lat     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_loop_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_loop_ram_arbiter
// Bench for loop_ram_arbiter with a behavioural async-RAM responder
// (programmable latency, optional hang). Expected playback samples and
// expected transaction directions are queued when stimulus is driven and
// popped when the DUT produces them.
// ----------------------------------------------------------------------------
module tb_loop_ram_arbiter;

  localparam int ADDR_W = 4;
  localparam int MEM_AW = 23;
  localparam int BASE   = 100;
  localparam int TMO    = 255;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                rec_en = 1'b0;
  logic                rec_valid = 1'b0;
  logic signed [15:0]  rec_data = '0;
  logic                rec_ready;
  logic                play_req = 1'b0;
  logic                play_valid;
  logic signed [15:0]  play_data;
  logic [ADDR_W-1:0]   loop_len = 4'd4;
  logic                clear = 1'b0;
  logic [ADDR_W-1:0]   rec_ptr;
  logic [ADDR_W-1:0]   play_ptr;
  logic                play_ovr;
  logic                err_timeout;

  loop_ram_arbiter_if #(.MEM_AW(MEM_AW)) mem_bus ();

  loop_ram_arbiter #(
    .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .BASE_ADDR(BASE), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rec_en(rec_en), .rec_valid(rec_valid),
    .rec_data(rec_data), .rec_ready(rec_ready), .play_req(play_req),
    .play_valid(play_valid), .play_data(play_data), .loop_len(loop_len),
    .clear(clear), .mem(mem_bus), .rec_ptr(rec_ptr), .play_ptr(play_ptr),
    .play_ovr(play_ovr), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] playq[$];
  logic        weq[$];

  // RAM responder
  logic [15:0] ram_model [16];
  bit          ram_init = 1'b0;
  int          ram_lat = 0;
  bit          ram_hang = 1'b0;
  int          ram_cnt = 0;
  logic [3:0]  ram_idx;
  bit          pre_en = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [15:0] pre_val = '0;

  always @(negedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 16; i++) ram_model[i] = '0;
      ram_init = 1'b1;
    end
    if (pre_en) ram_model[pre_idx] = pre_val;
    ram_idx = 4'(mem_bus.addr - MEM_AW'(BASE));
    if (!rst_n) begin
      mem_bus.done  = 1'b0;
      mem_bus.rdata = '0;
      ram_cnt       = 0;
    end else if (mem_bus.done) begin
      mem_bus.done = 1'b0;
      ram_cnt      = 0;
    end else if (mem_bus.req && !ram_hang) begin
      if (ram_cnt >= ram_lat) begin
        mem_bus.done = 1'b1;
        ram_cnt      = 0;
        if (mem_bus.we) ram_model[ram_idx] = mem_bus.wdata;
        else            mem_bus.rdata      = ram_model[ram_idx];
      end else begin
        ram_cnt++;
      end
    end else begin
      ram_cnt = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [15:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_en  = 1'b1;
    @(negedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic push_rec(input logic [15:0] d);
    int n;
    n = 0;
    while (!rec_ready) begin
      tick();
      n++;
      if (n > 100) begin
        $display("FAIL push_rec: rec_ready still %0b after %0d cycles, required 1", rec_ready, n);
        $fatal(1, "stalled");
      end
    end
    rec_valid = 1'b1;
    rec_data  = d;
    tick();
    rec_valid = 1'b0;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 400; i++) begin
      if (rec_ready && !mem_bus.req) return;
      tick();
    end
    $display("FAIL wait_idle: rec_ready=%0b req=%0b after 400 cycles, required 1/0", rec_ready, mem_bus.req);
    $fatal(1, "stalled");
  endtask

  task automatic pulse_play;
    play_req = 1'b1;
    tick();
    play_req = 1'b0;
  endtask

  task automatic test_reset;
    rec_en = 1'b0;
    rst_n  = 1'b0;
    tick(); tick();
    checks++; if (mem_bus.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", mem_bus.req); end
    checks++; if (mem_bus.we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", mem_bus.we); end
    checks++; if (mem_bus.addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", mem_bus.addr); end
    checks++; if (play_valid !== 1'b0) begin errors++; $display("FAIL reset_play_valid: got %0b want 0", play_valid); end
    checks++; if (play_data !== 16'sd0) begin errors++; $display("FAIL reset_play_data: got %0h want 0", play_data); end
    checks++; if (rec_ready !== 1'b0) begin errors++; $display("FAIL reset_rec_ready: got %0b want 0", rec_ready); end
    checks++; if (rec_ptr !== '0 || play_ptr !== '0) begin errors++; $display("FAIL reset_ptrs: got %0d/%0d want 0/0", rec_ptr, play_ptr); end
    checks++; if (play_ovr !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL reset_flags: got %0b/%0b want 0/0", play_ovr, err_timeout); end
    tick();
    rst_n  = 1'b1;
    rec_en = 1'b1;
    #1;
    checks++; if (rec_ready !== 1'b1) begin errors++; $display("FAIL rec_ready_after_reset: got %0b want 1", rec_ready); end
  endtask

  task automatic test_loop_basic;
    loop_len = 4'd4;
    ram_lat  = 1;
    for (int i = 1; i <= 4; i++) begin
      push_rec(16'(i));
      wait_idle();
    end
    checks++; if (rec_ptr !== 4'd0) begin errors++; $display("FAIL loop_rec_ptr: got %0d want 0", rec_ptr); end
    checks++; if (ram_model[3] !== 16'd4) begin errors++; $display("FAIL loop_ram3: got %0h want 4", ram_model[3]); end
    for (int i = 1; i <= 4; i++) begin
      playq.push_back(16'(i));
      pulse_play();
      for (int c = 0; c < 50 && !play_valid; c++) tick();
      checks++;
      if (!play_valid) begin
        errors++; $display("FAIL loop_play_valid: no pulse for sample %0d, want pulse", i);
        void'(playq.pop_front());
      end else begin
        logic [15:0] e;
        e = playq.pop_front();
        if (play_data !== e) begin errors++; $display("FAIL loop_play_data: got %0h want %0h", play_data, e); end
      end
      tick();
    end
    checks++; if (play_ptr !== 4'd0) begin errors++; $display("FAIL loop_play_ptr: got %0d want 0", play_ptr); end
  endtask

  task automatic test_arb_order;
    logic prev;
    do_reset();
    rec_en    = 1'b1;
    ram_lat   = 1;
    play_req  = 1'b1;
    rec_valid = 1'b1;
    rec_data  = 16'sh0055;
    weq.push_back(1'b0);
`ifdef OVERDUB_EN
    weq.push_back(1'b0);
`else
    weq.push_back(1'b1);
`endif
    playq.push_back(16'd1);
    tick();
    play_req  = 1'b0;
    rec_valid = 1'b0;
    prev = 1'b0;
    for (int c = 0; c < 60 && (weq.size() != 0 || playq.size() != 0); c++) begin
      if (mem_bus.req && !prev) begin
        logic e;
        e = weq.pop_front();
        checks++; if (mem_bus.we !== e) begin errors++; $display("FAIL arb_we: got %0b want %0b", mem_bus.we, e); end
      end
      if (play_valid && playq.size() != 0) begin
        logic [15:0] e;
        e = playq.pop_front();
        checks++; if (play_data !== e) begin errors++; $display("FAIL arb_play_data: got %0h want %0h", play_data, e); end
      end
      prev = mem_bus.req;
      tick();
    end
    checks++;
    if (weq.size() != 0 || playq.size() != 0) begin
      errors++; $display("FAIL arb_drain: %0d/%0d items left, want 0/0", weq.size(), playq.size());
      weq.delete(); playq.delete();
    end
    wait_idle();
  endtask

  task automatic test_timeout;
    int  n;
    bit  seen;
    do_reset();
    ram_hang = 1'b1;
    playq.push_back(16'd0);
    pulse_play();
    n = 0;
    seen = 1'b0;
    for (int c = 0; c < 320 && !seen; c++) begin
      if (mem_bus.req) n++;
      if (play_valid) begin
        logic [15:0] e;
        seen = 1'b1;
        e = playq.pop_front();
        checks++; if (play_data !== e) begin errors++; $display("FAIL tmo_play_data: got %0h want %0h", play_data, e); end
      end
      tick();
    end
    ram_hang = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL tmo_play_valid: no pulse, want pulse"); playq.delete(); end
    checks++; if (n != TMO) begin errors++; $display("FAIL tmo_req_cycles: got %0d want %0d", n, TMO); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_err: got %0b want 1", err_timeout); end
    checks++; if (play_ptr !== 4'd1) begin errors++; $display("FAIL tmo_play_ptr: got %0d want 1", play_ptr); end
  endtask

  task automatic test_overrun;
    int nv;
    do_reset();
    preload(4'd0, 16'h1234);
    ram_lat = 6;
    playq.push_back(16'h1234);
    pulse_play();
    pulse_play();
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      if (play_valid) begin
        nv++;
        if (playq.size() != 0) begin
          logic [15:0] e;
          e = playq.pop_front();
          checks++; if (play_data !== e) begin errors++; $display("FAIL ovr_play_data: got %0h want %0h", play_data, e); end
        end
      end
      tick();
    end
    checks++; if (nv != 1) begin errors++; $display("FAIL ovr_valid_count: got %0d want 1", nv); end
    checks++; if (play_ovr !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %0b want 1", play_ovr); end
    checks++; if (play_ptr !== 4'd1) begin errors++; $display("FAIL ovr_play_ptr: got %0d want 1", play_ptr); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (play_ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear_flag: got %0b want 0", play_ovr); end
    checks++; if (play_ptr !== 4'd0) begin errors++; $display("FAIL ovr_clear_ptr: got %0d want 0", play_ptr); end
    playq.delete();
  endtask

  task automatic test_clear_busy;
    do_reset();
    ram_lat = 6;
    pulse_play();
    tick(); tick();
    checks++; if (mem_bus.req !== 1'b1) begin errors++; $display("FAIL clrbusy_req: got %0b want 1", mem_bus.req); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int c = 0; c < 40 && mem_bus.req; c++) tick();
    tick(); tick();
    checks++; if (play_ptr !== 4'd0) begin errors++; $display("FAIL clrbusy_play_ptr: got %0d want 0", play_ptr); end
    checks++; if (mem_bus.req !== 1'b0) begin errors++; $display("FAIL clrbusy_idle: got req %0b want 0", mem_bus.req); end
  endtask

  task automatic test_wrap;
    do_reset();
    ram_lat  = 0;
    loop_len = 4'd0;
    rec_en   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_rec(16'(16'h0100 + i));
      wait_idle();
      if (i == 14) begin
        checks++; if (rec_ptr !== 4'd15) begin errors++; $display("FAIL wrap_ptr15: got %0d want 15", rec_ptr); end
      end
      if (i == 15) begin
        checks++; if (rec_ptr !== 4'd0) begin errors++; $display("FAIL wrap_ptr0: got %0d want 0", rec_ptr); end
      end
    end
    push_rec(16'h0200);
    for (int c = 0; c < 20 && !mem_bus.req; c++) tick();
    checks++; if (mem_bus.addr !== MEM_AW'(BASE)) begin errors++; $display("FAIL wrap_addr: got %0d want %0d", mem_bus.addr, BASE); end
    wait_idle();
    loop_len = 4'd4;
  endtask

`ifdef OVERDUB_EN
  task automatic test_overdub;
    do_reset();
    preload(4'd0, 16'h7000);
    preload(4'd1, 16'hFFFB);
    ram_lat  = 1;
    loop_len = 4'd4;
    rec_en   = 1'b1;
    push_rec(16'h2000);
    wait_idle();
    push_rec(16'h0003);
    wait_idle();
    checks++; if (ram_model[0] !== 16'h7FFF) begin errors++; $display("FAIL overdub_sat: got %0h want 7fff", ram_model[0]); end
    checks++; if (ram_model[1] !== 16'hFFFE) begin errors++; $display("FAIL overdub_sum: got %0h want fffe", ram_model[1]); end
  endtask
`endif

  initial begin
    test_reset();
    test_loop_basic();
    test_arb_order();
    test_timeout();
    test_overrun();
    test_clear_busy();
    test_wrap();
`ifdef OVERDUB_EN
    test_overdub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
